// File: rtl/etile_operand_station_pkg.sv
// Shared definitions for the E-tile operand station: operand slot encoding,
// required-operand mask bit positions, per-entry control state and the
// issue-register state encoding.
package etile_operand_station_pkg;

  // Operand slot encoding carried on op_dest_slot.
  localparam logic [1:0] SLOT_LEFT  = 2'd0;
  localparam logic [1:0] SLOT_RIGHT = 2'd1;
  localparam logic [1:0] SLOT_PRED  = 2'd2;
  localparam logic [1:0] SLOT_RSVD  = 2'd3;

  // Bit positions inside the {pred,right,left} needs/arrived masks.
  localparam int NEED_LEFT  = 0;
  localparam int NEED_RIGHT = 1;
  localparam int NEED_PRED  = 2;

  // Issue register states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } iss_state_e;

  // Control state of one instruction entry. The left/right operand values are
  // kept in separate DATA_W-wide arrays in the top so this struct stays
  // independent of the data width.
  typedef struct packed {
    logic       cfgd;     // entry mapped by cfg_valid
    logic [2:0] needs;    // required operands {pred,right,left}
    logic       pol;      // predicate value that enables issue
    logic [2:0] arrived;  // operands received {pred,right,left}
    logic       pred;     // received predicate value
    logic       done;     // issued or nullified
  } opstn_entry_t;

  // All required operands present and predicate (if needed) matches.
  function automatic logic entry_ready(input opstn_entry_t e);
    return e.cfgd & ~e.done & ((e.arrived & e.needs) == e.needs) &
           (~e.needs[NEED_PRED] | (e.pred == e.pol));
  endfunction

  // Predicate arrived with the non-enabling value: the entry retires silently.
  function automatic logic entry_nullify(input opstn_entry_t e);
    return e.cfgd & ~e.done & e.needs[NEED_PRED] & e.arrived[NEED_PRED] &
           (e.pred != e.pol);
  endfunction

endpackage

// File: rtl/etile_operand_station_if.sv
// Operand-network receiver port and ALU issue port of the E-tile operand
// station. The master side is the network receiver plus the ALU issue stage;
// the slave side is the station itself.
interface etile_operand_station_if #(
  parameter int DATA_W  = 32,
  parameter int INSTR_W = 7,
  parameter int IDX_W   = 3
);

  // Routed operand from the network receiver.
  logic               op_req;
  logic               op_ack;
  logic [DATA_W-1:0]  op_data;
  logic [INSTR_W-1:0] op_dest_instr;
  logic [1:0]         op_dest_slot;

  // Issue candidate towards the ALU.
  logic               iss_valid;
  logic               iss_ready;
  logic [IDX_W-1:0]   iss_idx;
  logic [DATA_W-1:0]  iss_left;
  logic [DATA_W-1:0]  iss_right;

  modport master (
    output op_req, op_data, op_dest_instr, op_dest_slot, iss_ready,
    input  op_ack, iss_valid, iss_idx, iss_left, iss_right
  );

  modport slave (
    input  op_req, op_data, op_dest_instr, op_dest_slot, iss_ready,
    output op_ack, iss_valid, iss_idx, iss_left, iss_right
  );

endinterface

// File: rtl/etile_operand_station_rr_arbiter.sv
// Round-robin picker: returns the first requesting entry at or after ptr,
// wrapping at NUM_SLOTS, as a one-hot grant plus its index.
module opstn_rr_arbiter #(
  parameter  int NUM_SLOTS = 8,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_SLOTS-1:0] gnt,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  // Scan from ptr upward; index arithmetic wraps because NUM_SLOTS is 2^IDX_W.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path through the block infers a latch.
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!any && req[ptr + IDX_W'(i)]) begin
        any = 1'b1;
        idx = ptr + IDX_W'(i);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/etile_operand_station.sv
// E-tile operand station: collects routed operands against locally mapped
// instruction entries and issues fully-ready entries round-robin to the ALU.
// Optional statistics counters are enabled with `define ETILE_OPSTN_STATS_EN.
module etile_operand_station
  import etile_operand_station_pkg::*;
#(
  parameter  int NUM_SLOTS = 8,
  parameter  int DATA_W    = 32,
  parameter  int INSTR_W   = 7,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  etile_operand_station_if.slave   bus,
  input  logic                     cfg_valid,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic [2:0]               cfg_needs,
  input  logic                     cfg_pred_pol,
  input  logic                     flush,
  input  logic                     revitalize,
  output logic                     err_pulse,
  output logic [15:0]              issued_cnt,
  output logic [15:0]              nullified_cnt
);

  opstn_entry_t      ent_q     [NUM_SLOTS];
  opstn_entry_t      ent_upd   [NUM_SLOTS];
  opstn_entry_t      ent_fin   [NUM_SLOTS];
  logic [DATA_W-1:0] left_q    [NUM_SLOTS];
  logic [DATA_W-1:0] right_q   [NUM_SLOTS];
  logic [DATA_W-1:0] left_upd  [NUM_SLOTS];
  logic [DATA_W-1:0] right_upd [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] ready_vec, null_vec, req_vec, gnt_vec;
  logic [IDX_W-1:0]     pick_idx, rr_ptr_q, iss_idx_q;
  logic                 pick_any, can_load, op_xfer, err_nxt, err_q;
  logic [IDX_W-1:0]     op_idx;
  logic [DATA_W-1:0]    iss_left_q, iss_right_q;
  iss_state_e           state_q;

  assign bus.op_ack = bus.op_req & ~flush & ~revitalize;
  assign op_xfer    = bus.op_req & bus.op_ack;
  assign op_idx     = bus.op_dest_instr[IDX_W-1:0];

  // Only the low instruction bits select the local entry.
  if (INSTR_W > IDX_W) begin : g_instr_hi
    logic unused_instr_hi;
    assign unused_instr_hi = ^bus.op_dest_instr[INSTR_W-1:IDX_W];
  end

  // Apply this cycle's operand arrival and configuration write to a working
  // copy, so a completing operand is visible to the picker in the same cycle.
  always_comb begin
    ent_upd   = ent_q;
    left_upd  = left_q;
    right_upd = right_q;
    err_nxt   = 1'b0;
    if (op_xfer) begin
      case (bus.op_dest_slot)
        SLOT_LEFT: begin
          if (ent_q[op_idx].arrived[NEED_LEFT]) err_nxt = 1'b1;
          else begin
            ent_upd[op_idx].arrived[NEED_LEFT] = 1'b1;
            left_upd[op_idx] = bus.op_data;
          end
        end
        SLOT_RIGHT: begin
          if (ent_q[op_idx].arrived[NEED_RIGHT]) err_nxt = 1'b1;
          else begin
            ent_upd[op_idx].arrived[NEED_RIGHT] = 1'b1;
            right_upd[op_idx] = bus.op_data;
          end
        end
        SLOT_PRED: begin
          if (ent_q[op_idx].arrived[NEED_PRED]) err_nxt = 1'b1;
          else begin
            ent_upd[op_idx].arrived[NEED_PRED] = 1'b1;
            ent_upd[op_idx].pred = bus.op_data[0];
          end
        end
        default: err_nxt = 1'b1;  // reserved slot: acked and dropped
      endcase
    end
    if (cfg_valid) begin
      ent_upd[cfg_idx].cfgd  = 1'b1;
      ent_upd[cfg_idx].needs = cfg_needs;
      ent_upd[cfg_idx].pol   = cfg_pred_pol;
    end
  end

  // Ready/nullify evaluation and retirement of picked or nullified entries.
  always_comb begin
    ready_vec = '0;
    null_vec  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      ready_vec[i] = entry_ready(ent_upd[i]);
      null_vec[i]  = entry_nullify(ent_upd[i]);
      ent_fin[i]      = ent_upd[i];
      ent_fin[i].done = ent_upd[i].done | gnt_vec[i] | null_vec[i];
    end
  end

  // A new pick may load when the issue register is empty or being drained.
  assign can_load = (state_q == ST_IDLE) | bus.iss_ready;
  assign req_vec  = ready_vec & {NUM_SLOTS{can_load}};

  opstn_rr_arbiter #(.NUM_SLOTS(NUM_SLOTS)) u_arb (
    .req (req_vec),
    .ptr (rr_ptr_q),
    .gnt (gnt_vec),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Entry state and operand storage; flush wipes, revitalize rearms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand storage is reset as well, so a freshly reset or flushed
      // entry can never present stale data on the issue outputs.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ent_q[i]   <= '0;
        left_q[i]  <= '0;
        right_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ent_q[i]   <= '0;
        left_q[i]  <= '0;
        right_q[i] <= '0;
      end
    end else if (revitalize) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ent_q[i].arrived <= '0;
        ent_q[i].done    <= 1'b0;
      end
    end else begin
      ent_q   <= ent_fin;
      left_q  <= left_upd;
      right_q <= right_upd;
    end
  end

  // Issue register FSM: IDLE loads a pick, HOLD keeps outputs until iss_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      iss_idx_q   <= '0;
      iss_left_q  <= '0;
      iss_right_q <= '0;
    end else if (flush) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
    end else if (revitalize) begin
      state_q <= ST_IDLE;
    end else if (can_load) begin
      if (pick_any) begin
        state_q     <= ST_HOLD;
        iss_idx_q   <= pick_idx;
        iss_left_q  <= left_upd[pick_idx];
        iss_right_q <= right_upd[pick_idx];
        rr_ptr_q    <= pick_idx + IDX_W'(1);
      end else begin
        state_q <= ST_IDLE;
      end
    end
  end

  // Error pulse for duplicate or reserved-slot arrivals, one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_nxt;
  end

  assign bus.iss_valid = (state_q == ST_HOLD);
  assign bus.iss_idx   = iss_idx_q;
  assign bus.iss_left  = iss_left_q;
  assign bus.iss_right = iss_right_q;
  assign err_pulse     = err_q;

`ifdef ETILE_OPSTN_STATS_EN
  logic [15:0]  issued_q, nullified_q;
  logic [IDX_W:0] null_n;
  logic [16:0]  null_sum;

  // Number of entries nullified this cycle (none while flushing/revitalizing).
  always_comb begin
    null_n = '0;
    if (!flush && !revitalize) begin
      for (int i = 0; i < NUM_SLOTS; i++) null_n = null_n + (IDX_W+1)'(null_vec[i]);
    end
    null_sum = {1'b0, nullified_q} + 17'(null_n);
  end

  // Saturating statistics counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q    <= '0;
      nullified_q <= '0;
    end else begin
      if (bus.iss_valid && bus.iss_ready && issued_q != 16'hFFFF)
        issued_q <= issued_q + 16'd1;
      nullified_q <= null_sum[16] ? 16'hFFFF : null_sum[15:0];
    end
  end

  assign issued_cnt    = issued_q;
  assign nullified_cnt = nullified_q;
`else
  assign issued_cnt    = '0;
  assign nullified_cnt = '0;
`endif

endmodule

// File: tb/tb_etile_operand_station.sv
// Self-checking bench for etile_operand_station: a vector table of single
// operand arrivals with expected issue outputs, then hand-written sequences
// for hold, nullify, round-robin order, errors, revitalize, flush and reset.
module tb_etile_operand_station;
  import etile_operand_station_pkg::*;

`ifdef ETILE_OPSTN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [2:0]  cfg_needs = '0;
  logic        cfg_pred_pol = 1'b0;
  logic        flush = 1'b0;
  logic        revitalize = 1'b0;
  logic        err_pulse;
  logic [15:0] issued_cnt, nullified_cnt;

  int errors = 0;
  int checks = 0;
  int exp_iss = 0;
  int exp_null = 0;

  etile_operand_station_if #(.DATA_W(32), .INSTR_W(7), .IDX_W(3)) bus ();

  etile_operand_station #(.NUM_SLOTS(8), .DATA_W(32), .INSTR_W(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .cfg_valid     (cfg_valid),
    .cfg_idx       (cfg_idx),
    .cfg_needs     (cfg_needs),
    .cfg_pred_pol  (cfg_pred_pol),
    .flush         (flush),
    .revitalize    (revitalize),
    .err_pulse     (err_pulse),
    .issued_cnt    (issued_cnt),
    .nullified_cnt (nullified_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  instr;
    logic [1:0]  slot;
    logic [31:0] data;
    logic        exp_valid;
    logic [2:0]  exp_idx;
    logic [31:0] exp_left;
    logic [31:0] exp_right;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] instr, input logic [1:0] slot, input logic [31:0] data);
    bus.op_req        = 1'b1;
    bus.op_dest_instr = instr;
    bus.op_dest_slot  = slot;
    bus.op_data       = data;
    tick();
    bus.op_req = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [2:0] needs, input logic pol);
    cfg_valid    = 1'b1;
    cfg_idx      = idx;
    cfg_needs    = needs;
    cfg_pred_pol = pol;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic expect_iss(input string name, input logic v, input logic [2:0] idx,
                            input logic [31:0] l, input logic [31:0] r);
    check({name, " valid"}, 32'(bus.iss_valid), 32'(v));
    if (v) begin
      check({name, " idx"},   32'(bus.iss_idx), 32'(idx));
      check({name, " left"},  bus.iss_left, l);
      check({name, " right"}, bus.iss_right, r);
    end
  endtask

  task automatic check_counters(input string name);
    check({name, " issued_cnt"},    32'(issued_cnt),    STATS ? 32'(exp_iss)  : 32'd0);
    check({name, " nullified_cnt"}, 32'(nullified_cnt), STATS ? 32'(exp_null) : 32'd0);
  endtask

  initial begin
    bus.op_req = 1'b0; bus.op_data = '0; bus.op_dest_instr = '0;
    bus.op_dest_slot = '0; bus.iss_ready = 1'b0;

    // Vector table: {instr, slot, data, valid, idx, left, right, err}.
    vecs[0]  = '{7'd1,  SLOT_LEFT,  32'h11, 1'b1, 3'd1, 32'h11, 32'h0,  1'b0};
    vecs[1]  = '{7'd4,  SLOT_LEFT,  32'h44, 1'b0, 3'd0, 32'h0,  32'h0,  1'b0};
    vecs[2]  = '{7'd4,  SLOT_RIGHT, 32'h45, 1'b1, 3'd4, 32'h44, 32'h45, 1'b0};
    vecs[3]  = '{7'd9,  SLOT_RIGHT, 32'h99, 1'b0, 3'd0, 32'h0,  32'h0,  1'b0};
    vecs[4]  = '{7'd3,  SLOT_RIGHT, 32'h33, 1'b1, 3'd3, 32'h0,  32'h33, 1'b0};
    vecs[5]  = '{7'd6,  SLOT_PRED,  32'h0,  1'b0, 3'd0, 32'h0,  32'h0,  1'b0};
    vecs[6]  = '{7'd6,  SLOT_LEFT,  32'h66, 1'b1, 3'd6, 32'h66, 32'h0,  1'b0};
    vecs[7]  = '{7'd7,  SLOT_LEFT,  32'h77, 1'b0, 3'd0, 32'h0,  32'h0,  1'b0};
    vecs[8]  = '{7'd7,  SLOT_PRED,  32'h2,  1'b0, 3'd0, 32'h0,  32'h0,  1'b0};
    vecs[9]  = '{7'd7,  SLOT_PRED,  32'h1,  1'b0, 3'd0, 32'h0,  32'h0,  1'b1};
    vecs[10] = '{7'd15, SLOT_RSVD,  32'h5,  1'b0, 3'd0, 32'h0,  32'h0,  1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset op_ack", 32'(bus.op_ack), 32'd0);
    check("reset iss_valid", 32'(bus.iss_valid), 32'd0);
    check("reset iss_idx", 32'(bus.iss_idx), 32'd0);
    check("reset iss_left", bus.iss_left, 32'd0);
    check("reset iss_right", bus.iss_right, 32'd0);
    check("reset err_pulse", 32'(err_pulse), 32'd0);
    check_counters("reset");
    rst_n = 1'b1;
    tick();

    // Table-driven arrivals, iss_ready held high so each pick drains next cycle.
    cfg(3'd1, 3'b001, 1'b0);
    cfg(3'd3, 3'b010, 1'b0);
    cfg(3'd4, 3'b011, 1'b0);
    cfg(3'd6, 3'b101, 1'b0);
    cfg(3'd7, 3'b101, 1'b1);
    bus.iss_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus.op_req = 1'b1;
      bus.op_dest_instr = vecs[i].instr;
      bus.op_dest_slot  = vecs[i].slot;
      bus.op_data       = vecs[i].data;
      #1;
      check($sformatf("row%0d op_ack", i), 32'(bus.op_ack), 32'd1);
      @(posedge clk);
      #1;
      bus.op_req = 1'b0;
      expect_iss($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_idx,
                 vecs[i].exp_left, vecs[i].exp_right);
      check($sformatf("row%0d err", i), 32'(err_pulse), 32'(vecs[i].exp_err));
    end
    exp_iss = 4; exp_null = 1;
    tick();
    check("err one-cycle", 32'(err_pulse), 32'd0);
    check_counters("table");
    bus.iss_ready = 1'b0;

    // A: two-operand entry, latency and HOLD stability.
    flush = 1'b1; tick(); flush = 1'b0;
    cfg(3'd2, 3'b011, 1'b0);
    send(7'd2, SLOT_LEFT, 32'hA);
    expect_iss("A left only", 1'b0, 3'd0, 32'h0, 32'h0);
    send(7'd2, SLOT_RIGHT, 32'hB);
    expect_iss("A issue", 1'b1, 3'd2, 32'hA, 32'hB);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_iss($sformatf("A hold%0d", i), 1'b1, 3'd2, 32'hA, 32'hB);
    end
    bus.iss_ready = 1'b1; tick(); bus.iss_ready = 1'b0; exp_iss++;
    expect_iss("A drained", 1'b0, 3'd0, 32'h0, 32'h0);

    // B: predicate nullify, then revitalize and issue with matching predicate.
    cfg(3'd5, 3'b111, 1'b1);
    send(7'd5, SLOT_PRED, 32'h0);
    send(7'd5, SLOT_LEFT, 32'h50);
    send(7'd5, SLOT_RIGHT, 32'h51);
    expect_iss("B nullified", 1'b0, 3'd0, 32'h0, 32'h0);
    exp_null++;
    check_counters("B null");
    revitalize = 1'b1; tick(); revitalize = 1'b0;
    send(7'd5, SLOT_PRED, 32'h1);
    send(7'd5, SLOT_LEFT, 32'h52);
    send(7'd5, SLOT_RIGHT, 32'h53);
    expect_iss("B issue", 1'b1, 3'd5, 32'h52, 32'h53);
    bus.iss_ready = 1'b1; tick(); bus.iss_ready = 1'b0; exp_iss++;
    check_counters("B issued");

    // C: round-robin order 1,3,6 behind a held entry 0; pointer then at 7.
    flush = 1'b1; tick(); flush = 1'b0;
    cfg(3'd0, 3'b001, 1'b0); cfg(3'd1, 3'b001, 1'b0); cfg(3'd3, 3'b001, 1'b0);
    cfg(3'd6, 3'b001, 1'b0); cfg(3'd2, 3'b001, 1'b0); cfg(3'd7, 3'b001, 1'b0);
    send(7'd0, SLOT_LEFT, 32'hC0);
    send(7'd6, SLOT_LEFT, 32'hC6);
    send(7'd3, SLOT_LEFT, 32'hC3);
    send(7'd1, SLOT_LEFT, 32'hC1);
    expect_iss("C hold0", 1'b1, 3'd0, 32'hC0, 32'h0);
    bus.iss_ready = 1'b1;
    tick(); exp_iss++; expect_iss("C first", 1'b1, 3'd1, 32'hC1, 32'h0);
    tick(); exp_iss++; expect_iss("C second", 1'b1, 3'd3, 32'hC3, 32'h0);
    tick(); exp_iss++; expect_iss("C third", 1'b1, 3'd6, 32'hC6, 32'h0);
    bus.iss_ready = 1'b0;
    send(7'd2, SLOT_LEFT, 32'hC2);
    send(7'd7, SLOT_LEFT, 32'hC7);
    expect_iss("C hold6", 1'b1, 3'd6, 32'hC6, 32'h0);
    bus.iss_ready = 1'b1;
    tick(); exp_iss++; expect_iss("C ptr7 pick", 1'b1, 3'd7, 32'hC7, 32'h0);
    tick(); exp_iss++; expect_iss("C wrap pick", 1'b1, 3'd2, 32'hC2, 32'h0);
    tick(); exp_iss++; expect_iss("C empty", 1'b0, 3'd0, 32'h0, 32'h0);
    bus.iss_ready = 1'b0;
    check_counters("C");

    // D: duplicate arrival dropped, reserved slot acked with error.
    flush = 1'b1; tick(); flush = 1'b0;
    cfg(3'd4, 3'b011, 1'b0);
    send(7'd4, SLOT_LEFT, 32'hD1);
    check("D first err", 32'(err_pulse), 32'd0);
    send(7'd4, SLOT_LEFT, 32'hD2);
    check("D dup err", 32'(err_pulse), 32'd1);
    tick();
    check("D dup err drop", 32'(err_pulse), 32'd0);
    send(7'd4, SLOT_RIGHT, 32'hD3);
    expect_iss("D issue", 1'b1, 3'd4, 32'hD1, 32'hD3);
    bus.op_req = 1'b1; bus.op_dest_instr = 7'd4; bus.op_dest_slot = SLOT_RSVD;
    #1;
    check("D rsvd op_ack", 32'(bus.op_ack), 32'd1);
    @(posedge clk); #1;
    bus.op_req = 1'b0;
    check("D rsvd err", 32'(err_pulse), 32'd1);
    expect_iss("D held", 1'b1, 3'd4, 32'hD1, 32'hD3);
    bus.iss_ready = 1'b1; tick(); bus.iss_ready = 1'b0; exp_iss++;
    expect_iss("D drained", 1'b0, 3'd0, 32'h0, 32'h0);

    // E: revitalize during HOLD, then reissue with the kept configuration.
    flush = 1'b1; tick(); flush = 1'b0;
    cfg(3'd0, 3'b011, 1'b0);
    send(7'd0, SLOT_LEFT, 32'hE0);
    send(7'd0, SLOT_RIGHT, 32'hE1);
    expect_iss("E hold", 1'b1, 3'd0, 32'hE0, 32'hE1);
    revitalize = 1'b1;
    bus.op_req = 1'b1; bus.op_dest_instr = 7'd0; bus.op_dest_slot = SLOT_LEFT;
    bus.op_data = 32'hEE;
    #1;
    check("E revit op_ack", 32'(bus.op_ack), 32'd0);
    @(posedge clk); #1;
    revitalize = 1'b0; bus.op_req = 1'b0;
    expect_iss("E revit drop", 1'b0, 3'd0, 32'h0, 32'h0);
    send(7'd0, SLOT_LEFT, 32'hE2);
    send(7'd0, SLOT_RIGHT, 32'hE3);
    expect_iss("E reissue", 1'b1, 3'd0, 32'hE2, 32'hE3);
    bus.iss_ready = 1'b1; tick(); bus.iss_ready = 1'b0; exp_iss++;

    // F: flush blocks op_ack and unconfigures; operand waits for cfg.
    cfg(3'd5, 3'b001, 1'b0);
    flush = 1'b1;
    bus.op_req = 1'b1; bus.op_dest_instr = 7'd5; bus.op_dest_slot = SLOT_LEFT;
    bus.op_data = 32'hFF;
    #1;
    check("F flush op_ack", 32'(bus.op_ack), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; bus.op_req = 1'b0;
    send(7'd5, SLOT_LEFT, 32'h55);
    expect_iss("F unconfigured", 1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    expect_iss("F still idle", 1'b0, 3'd0, 32'h0, 32'h0);
    check_counters("F");
    cfg(3'd5, 3'b001, 1'b0);
    expect_iss("F cfg issue", 1'b1, 3'd5, 32'h55, 32'h0);

    // Asynchronous reset in the middle of HOLD.
    rst_n = 1'b0;
    #1;
    check("rst iss_valid", 32'(bus.iss_valid), 32'd0);
    check("rst iss_left", bus.iss_left, 32'd0);
    exp_iss = 0; exp_null = 0;
    check_counters("rst");
    tick();
    rst_n = 1'b1;
    tick();
    expect_iss("post rst", 1'b0, 3'd0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/etile_operand_station.md
Name: etile_operand_station

Overview:
Per-E-tile reservation station that sits directly downstream of the operand routing network's receiver side. It accepts routed operands tagged with a destination instruction number and slot (left/right/predicate), and holds them against locally mapped instruction entries. It selects fully-ready entries round-robin and presents them to the E-tile ALU issue stage. Supports block flush and S-morph revitalize.

Parameters:
NUM_SLOTS, 8, instruction entries per E-tile (power of 2, 2..32)
DATA_W, 32, operand data width
INSTR_W, 7, destination instruction number width
IDX_W, $clog2(NUM_SLOTS), local entry index width (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
op_req  in  1  operand valid from network receiver
op_ack  out  1  operand accepted (combinational)
op_data  in  DATA_W  operand value
op_dest_instr  in  INSTR_W  destination instruction number; low IDX_W bits select entry
op_dest_slot  in  2  0=left, 1=right, 2=predicate, 3=reserved
cfg_valid  in  1  write entry configuration
cfg_idx  in  IDX_W  entry to configure
cfg_needs  in  3  required-operand mask {pred,right,left}
cfg_pred_pol  in  1  predicate value that enables issue
iss_valid  out  1  issue candidate valid (registered)
iss_ready  in  1  ALU accepts issue
iss_idx  out  IDX_W  issued entry index
iss_left  out  DATA_W  left operand
iss_right  out  DATA_W  right operand
flush  in  1  block commit/abort: clear everything
revitalize  in  1  S-morph loop reset: clear arrivals/issued, keep config
err_pulse  out  1  one-cycle pulse: reserved slot or duplicate arrival
issued_cnt  out  16  issue count (optional feature)
nullified_cnt  out  16  nullification count (optional feature)

Behaviour:
- Reset: all entries unconfigured, arrived=0, issued=0, data=0; iss_valid=0, iss_idx=0, iss_left/right=0, err_pulse=0, counters=0, round-robin pointer=0.
- Entry state: cfgd, needs[2:0], pol, arrived[2:0], left, right, pred, done.
- op_ack = op_req & ~flush & ~revitalize. An operand transfers when op_req & op_ack.
- Left/right arrival stores data and sets the arrived bit. Predicate arrival stores op_data[0].
- An arrival to a slot whose arrived bit is already set is dropped; err_pulse fires the next cycle.
- Reserved slot (3): acked and dropped; err_pulse fires the next cycle.
- Arrival at an unconfigured entry is stored. The entry becomes eligible once it is configured.
- cfg_valid sets cfgd, needs and pol. It does not alter arrived bits or data. If cfg and an operand target the same entry in the same cycle, both take effect.
- Ready condition for an entry: cfgd & ~done & ((arrived & needs) == needs) & (~needs[2] | pred == pol).
- Nullify: cfgd & ~done & needs[2] & arrived[2] & pred != pol sets done. No issue occurs, and nullified_cnt increments.
- Issue register, state IDLE: pick the first ready entry at or after the rr pointer, wrapping at NUM_SLOTS. Load iss_idx/left/right, set iss_valid, set that entry's done, and move the pointer to the pick+1 modulo NUM_SLOTS.
- Issue register, state HOLD: iss_valid=1 with outputs stable until iss_ready. On the iss_ready cycle, return to IDLE. The next pick may load in that same cycle (back-to-back issue, one per cycle).
- Latency: an operand completing an entry in cycle N gives iss_valid at the earliest in cycle N+1.
- flush: next cycle all entries cleared (including cfgd), iss_valid=0, pointer=0. Counters are not cleared.
- revitalize: arrived=0 and done=0, cfgd/needs/pol kept, iss_valid dropped.
- Priority when simultaneous: flush > revitalize > issue/arrival/cfg.
- rst_n mid-operation: immediate return to reset values.
- Counters saturate at 16'hFFFF.

Optional Feature:
ETILE_OPSTN_STATS_EN:
- Defined: issued_cnt and nullified_cnt are live saturating 16-bit counters. They are cleared only by reset. issued_cnt increments on iss_valid & iss_ready.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package gets: slot encoding constants (SLOT_LEFT/RIGHT/PRED/RSVD), the needs-mask bit positions, and the opstn_entry_t struct.
- One sub-module: opstn_rr_arbiter. Parameterized by NUM_SLOTS, it takes a request vector and a pointer and returns a one-hot grant, index and any-valid.

Test Plan:
- cfg idx2 needs=3'b011. Send left=0xA then right=0xB to instr 2 → iss_valid one cycle after right arrives, iss_idx=2, left=0xA, right=0xB. Hold iss_ready=0 for 3 cycles → outputs stable.
- cfg idx5 needs=3'b111 pol=1. Send pred=0 plus left and right → no issue, done set, nullified_cnt=1. Repeat with pred=1 → issue, issued_cnt=1.
- Entries 1, 3 and 6 all ready in the same cycle with iss_ready=1 → issue order 1, 3, 6 on consecutive cycles. Pointer ends at 7.
- Send left to instr 4 twice → second value dropped, err_pulse high for 1 cycle, iss_left shows the first value. Send dest_slot=3 → op_ack=1, err_pulse=1.
- Entry 0 in HOLD. Assert revitalize → iss_valid=0 next cycle. Resend operands → entry 0 reissues with the same config.
- flush while op_req=1 → op_ack=0. All entries become unconfigured and a later operand alone does not issue. Deassert rst_n mid-HOLD → iss_valid=0 immediately.
